absorb_load_stage: RTL and testbench

Front-end of the SHAKE pipeline, the counterpart to the squeeze/dump stage. Accepts a byte-length message as a stream of w-bit words over a valid/ready handshake. Packs the words little-endian into a rate-sized block buffer and applies SHAKE padding (0x1F ... 0x80). Hands each complete block to the permutation stage through a full/read handshake, flagging the final block of the message.

---
 rtl/absorb_load_stage_if.sv | 32 +++
 rtl/absorb_load_stage.sv | 156 +++++++++++++++
 tb/tb_absorb_load_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/absorb_load_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// absorb_load_stage_if: message stream in, rate block out, for the SHAKE absorb stage
// Revision: 1.0
// ----------------------------------------------------------------------------
interface absorb_load_stage_if #(
    parameter int W        = 64,
    parameter int RATE_MAX = 1344
);
    logic                start;
    logic [31:0]         input_size;
    logic [1:0]          operation_mode;
    logic [W-1:0]        data_i;
    logic                valid_i;
    logic                ready_i;
    logic [RATE_MAX-1:0] rate_input;
    logic [1:0]          operation_mode_out;
    logic                input_buffer_full;
    logic                input_buffer_rd;
    logic                last_input_block;

    modport master (
        output start, input_size, operation_mode, data_i, valid_i, input_buffer_rd,
        input  ready_i, rate_input, operation_mode_out, input_buffer_full, last_input_block
    );

    modport slave (
        input  start, input_size, operation_mode, data_i, valid_i, input_buffer_rd,
        output ready_i, rate_input, operation_mode_out, input_buffer_full, last_input_block
    );
endinterface
`default_nettype wire

// File: rtl/absorb_load_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// absorb_load_stage: packs message words into rate blocks, applies SHAKE padding
// Revision: 1.0
// ----------------------------------------------------------------------------
module absorb_load_stage #(
    parameter int W        = 64,
    parameter int RATE_MAX = 1344
) (
    input  wire logic          clk,
    input  wire logic          rst,
    absorb_load_stage_if.slave bus
);
    localparam int MAX_WORDS = RATE_MAX / W;
    localparam int IDX_W     = $clog2(MAX_WORDS + 1);
    localparam int POS_W     = $clog2(RATE_MAX / 8 + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        FULL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         bytes_rem_q, bytes_rem_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic [1:0]          mode_q, mode_d;
    logic [POS_W-1:0]    pad_pos_q, pad_pos_d;
    logic                last_q, last_d;
    logic                pend_pad_q, pend_pad_d;
    logic [RATE_MAX-1:0] buf_q, buf_d;

    logic                is_shake256;
    logic [IDX_W-1:0]    rate_words;
    logic [POS_W-1:0]    rate_bytes;
    logic [3:0]          nb;
    logic [W-1:0]        word_masked;

    // Only mode 01 selects the smaller SHAKE256 rate; 10/11 fall back to SHAKE128.
    assign is_shake256 = (mode_q == 2'b01);
    assign rate_words  = is_shake256 ? IDX_W'(17)  : IDX_W'(21);
    assign rate_bytes  = is_shake256 ? POS_W'(136) : POS_W'(168);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bytes_rem_q <= '0;
            word_idx_q  <= '0;
            mode_q      <= '0;
            pad_pos_q   <= '0;
            last_q      <= 1'b0;
            pend_pad_q  <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            bytes_rem_q <= bytes_rem_d;
            word_idx_q  <= word_idx_d;
            mode_q      <= mode_d;
            pad_pos_q   <= pad_pos_d;
            last_q      <= last_d;
            pend_pad_q  <= pend_pad_d;
            buf_q       <= buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bytes_rem_d = bytes_rem_q;
        word_idx_d  = word_idx_q;
        mode_d      = mode_q;
        pad_pos_d   = pad_pos_q;
        last_d      = last_q;
        pend_pad_d  = pend_pad_q;
        buf_d       = buf_q;

        nb          = (bytes_rem_q >= 32'd8) ? 4'd8 : bytes_rem_q[3:0];
        word_masked = '0;
        for (int k = 0; k < W / 8; k++) begin
            if (4'(k) < nb) begin
                word_masked[8*k +: 8] = bus.data_i[8*k +: 8];
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bytes_rem_d = bus.input_size;
                    mode_d      = bus.operation_mode;
                    word_idx_d  = '0;
                    pad_pos_d   = '0;
                    last_d      = 1'b0;
                    pend_pad_d  = 1'b0;
                    buf_d       = '0;
                    state_d     = (bus.input_size == 32'd0) ? PAD : LOAD;
                end
            end

            LOAD: begin
                if (bus.valid_i) begin
                    buf_d[int'(word_idx_q)*W +: W] = word_masked;
                    bytes_rem_d = bytes_rem_q - 32'(nb);
                    word_idx_d  = word_idx_q + IDX_W'(1);
                    if (bytes_rem_d == 32'd0) begin
                        pad_pos_d = {word_idx_q, 3'b000} + POS_W'(nb);
                        if (pad_pos_d < rate_bytes) begin
                            state_d = PAD;
                        end else begin
                            // Message ended exactly on the block edge: padding gets its own block.
                            state_d    = FULL;
                            last_d     = 1'b0;
                            pend_pad_d = 1'b1;
                        end
                    end else if (word_idx_d == rate_words) begin
                        state_d = FULL;
                        last_d  = 1'b0;
                    end
                end
            end

            PAD: begin
                buf_d[int'(pad_pos_q)*8 +: 8]        = buf_d[int'(pad_pos_q)*8 +: 8] ^ 8'h1F;
                buf_d[(int'(rate_bytes)-1)*8 +: 8]   = buf_d[(int'(rate_bytes)-1)*8 +: 8] ^ 8'h80;
                last_d  = 1'b1;
                state_d = FULL;
            end

            FULL: begin
                if (bus.input_buffer_rd) begin
                    buf_d      = '0;
                    word_idx_d = '0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else if (pend_pad_q) begin
                        pad_pos_d  = '0;
                        pend_pad_d = 1'b0;
                        state_d    = PAD;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.ready_i            = (state_q == LOAD);
    assign bus.input_buffer_full  = (state_q == FULL);
    assign bus.rate_input         = buf_q;
    assign bus.operation_mode_out = mode_q;
    assign bus.last_input_block   = last_q;

endmodule
`default_nettype wire

// File: tb/tb_absorb_load_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_absorb_load_stage: random and directed messages against a padded-byte-array model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_absorb_load_stage;
    localparam int W        = 64;
    localparam int RATE_MAX = 1344;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    absorb_load_stage_if #(.W(W), .RATE_MAX(RATE_MAX)) bus ();

    absorb_load_stage #(.W(W), .RATE_MAX(RATE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [RATE_MAX-1:0] obs, input logic [RATE_MAX-1:0] exp);
        int j;
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            j = 0;
            for (int k = RATE_MAX/64 - 1; k >= 0; k--) begin
                if (obs[k*64 +: 64] !== exp[k*64 +: 64]) j = k;
            end
            $display("FAIL %s: word %0d got %h want %h", tag, j, obs[j*64 +: 64], exp[j*64 +: 64]);
        end
    endtask

    // pat: 0 = random words, random valid; 1 = all-0xFF words, valid held high;
    //      2 = random words with last word 0xAABBCCDD_11223344, valid held high.
    task automatic run_msg(input int size, input logic [1:0] mode, input int pat, input int rd_delay);
        int          rate, nw, nblk;
        logic [63:0] words[$];
        logic [7:0]  pb[];
        logic [63:0] w;

        rate = (mode == 2'b01) ? 136 : 168;
        nw   = (size + 7) / 8;
        nblk = size / rate + 1;

        words.delete();
        for (int i = 0; i < nw; i++) begin
            w = {$urandom, $urandom};
            if (pat == 1) w = '1;
            if (pat == 2 && i == nw - 1) w = 64'hAABBCCDD_11223344;
            words.push_back(w);
        end

        pb = new[nblk * rate];
        for (int i = 0; i < nblk * rate; i++) pb[i] = 8'h00;
        for (int i = 0; i < size; i++) pb[i] = words[i/8][8*(i%8) +: 8];
        pb[size]            = pb[size] ^ 8'h1F;
        pb[nblk * rate - 1] = pb[nblk * rate - 1] ^ 8'h80;

        @(negedge clk);
        bus.start          = 1'b1;
        bus.input_size     = size;
        bus.operation_mode = mode;
        @(negedge clk);
        bus.start = 1'b0;
        check("ready_after_start", bus.ready_i, (size != 0));

        fork
            begin
                int idx;
                int guard;
                idx   = 0;
                guard = 0;
                while (idx < nw && guard < 5000) begin
                    bus.valid_i = (pat != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    bus.data_i  = bus.valid_i ? words[idx] : {$urandom, $urandom};
                    if (bus.valid_i && bus.ready_i) idx++;
                    @(negedge clk);
                    guard++;
                end
                bus.valid_i = 1'b0;
                if (idx < nw) check("producer_timeout", idx, nw);
            end
            begin
                for (int b = 0; b < nblk; b++) begin
                    int                  guard;
                    int                  d;
                    logic [RATE_MAX-1:0] exp;
                    logic [RATE_MAX-1:0] snap;
                    guard = 0;
                    while (!bus.input_buffer_full && guard < 5000) begin
                        bus.input_buffer_rd = ($urandom_range(0, 7) == 0);
                        @(negedge clk);
                        guard++;
                    end
                    bus.input_buffer_rd = 1'b0;
                    if (!bus.input_buffer_full) begin
                        check("full_timeout", 0, 1);
                        break;
                    end
                    exp = '0;
                    for (int i = 0; i < rate; i++) exp[8*i +: 8] = pb[b*rate + i];
                    check("block_data", bus.rate_input, exp);
                    check("last_flag", bus.last_input_block, (b == nblk - 1));
                    check("mode_out", bus.operation_mode_out, mode);
                    check("ready_when_full", bus.ready_i, 0);
                    snap = bus.rate_input;
                    d    = (rd_delay < 0) ? $urandom_range(0, 4) : rd_delay;
                    repeat (d) begin
                        @(negedge clk);
                        check("hold_data", bus.rate_input, snap);
                        check("hold_ready", bus.ready_i, 0);
                        check("hold_full", bus.input_buffer_full, 1);
                    end
                    bus.input_buffer_rd = 1'b1;
                    @(negedge clk);
                    bus.input_buffer_rd = 1'b0;
                    check("drained", bus.input_buffer_full, 0);
                    if (b == nblk - 1)
                        check("idle_after_last", bus.ready_i, 0);
                    else
                        check("ready_between_blocks", bus.ready_i,
                              !((b == nblk - 2) && (size % rate == 0)));
                end
            end
        join
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rate_input"}, bus.rate_input, 0);
        check({tag, "_ready"}, bus.ready_i, 0);
        check({tag, "_full"}, bus.input_buffer_full, 0);
        check({tag, "_last"}, bus.last_input_block, 0);
        check({tag, "_mode_out"}, bus.operation_mode_out, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start           = 1'b0;
        bus.input_size      = '0;
        bus.operation_mode  = '0;
        bus.data_i          = '0;
        bus.valid_i         = 1'b0;
        bus.input_buffer_rd = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        run_msg(0,   2'b00, 0, -1);
        run_msg(167, 2'b00, 1, -1);
        run_msg(168, 2'b00, 0, -1);
        run_msg(20,  2'b01, 2, -1);
        run_msg(200, 2'b01, 1, 10);
        run_msg(136, 2'b01, 0, -1);
        run_msg(9,   2'b10, 0, -1);

        // Abort a long message partway through loading.
        @(negedge clk);
        bus.start          = 1'b1;
        bus.input_size     = 300;
        bus.operation_mode = 2'b01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) begin
            bus.valid_i = 1'b1;
            bus.data_i  = {$urandom, $urandom};
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1 check_all_zero("midload_reset");
        bus.valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_msg(30, 2'b00, 0, -1);

        for (int t = 0; t < 8; t++) begin
            run_msg($urandom_range(0, 400), 2'($urandom_range(0, 3)), 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
